cmac_dual_group_ctrl: RTL

CMAC_DUAL_GROUP_CTRL -- requirements
Module: cmac_dual_group_ctrl

---
 rtl/cmac_dual_group_ctrl_if.sv | 35 +++
 rtl/cmac_dual_group_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cmac_dual_group_ctrl_if.sv
// Bus bundle between the CMAC dual-group sequencer and its environment.
// The register file, the datapath and software-facing status all attach through it.
interface cmac_dual_group_ctrl_if #(
   parameter int CNT_W = 32
);
   // Environment -> controller
   logic [1:0]       op_en_trigger;
   logic             op_en_wr_val;
   logic             ptr_wr_en;
   logic             ptr_wr_data;
   logic             dp_done;

   // Controller -> environment
   logic [1:0]       op_en;
   logic             producer;
   logic             consumer;
   logic             dp_start;
   logic             dp_sel;
   logic [1:0]       done_intr;
   logic             wr_err;
   logic             ctrl_busy;
   logic [CNT_W-1:0] busy_cycles;

   modport master (
      output op_en_trigger, op_en_wr_val, ptr_wr_en, ptr_wr_data, dp_done,
      input  op_en, producer, consumer, dp_start, dp_sel, done_intr, wr_err,
             ctrl_busy, busy_cycles
   );

   modport slave (
      input  op_en_trigger, op_en_wr_val, ptr_wr_en, ptr_wr_data, dp_done,
      output op_en, producer, consumer, dp_start, dp_sel, done_intr, wr_err,
             ctrl_busy, busy_cycles
   );
endinterface

// File: rtl/cmac_dual_group_ctrl.sv
// CMAC dual register-group sequencer.
// Two register groups are programmed by software and launched on the MAC
// datapath in strict ping-pong order. The consumer pointer selects the group
// that runs next. A group may only be launched once its op_en bit is set.
// Writes to op_en of the group currently running are rejected and flagged.
module cmac_dual_group_ctrl #(
   parameter int CNT_W = 32
) (
   input logic                   nvdla_core_clk,
   input logic                   nvdla_core_rst,
   cmac_dual_group_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_en_q, op_en_d;
   logic             producer_q, producer_d;
   logic             consumer_q, consumer_d;
   logic             wr_err_q, wr_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       grp_active_s;

   // A group is locked against op_en writes while it owns the datapath
   assign grp_active_s[0] = (state_q != ST_IDLE) && (consumer_q == 1'b0);
   assign grp_active_s[1] = (state_q != ST_IDLE) && (consumer_q == 1'b1);

   // Sequencer state register
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencer next-state: launch the consumer group once its op_en is set
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (op_en_q[consumer_q]) begin
               state_d = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: state_d = ST_BUSY;
         ST_BUSY: begin
            if (bus.dp_done) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_BUSY;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // op_en write arbitration, completion clear and write-error detection
   always_comb begin
      op_en_d  = op_en_q;
      wr_err_d = 1'b0;
      for (int g = 0; g < 2; g++) begin
         if (bus.op_en_trigger[g]) begin
            if (grp_active_s[g]) begin
               wr_err_d = 1'b1;
            end else begin
               op_en_d[g] = bus.op_en_wr_val;
            end
         end else begin
            op_en_d[g] = op_en_q[g];
         end
      end
      // The finishing group can never be written in DONE (it is active),
      // so this clear never collides with a legal write to the same bit.
      if (state_q == ST_DONE) begin
         op_en_d[consumer_q] = 1'b0;
      end else begin
         op_en_d[consumer_q] = op_en_d[consumer_q];
      end
   end

   // Pointer updates and the saturating busy-cycle counter
   always_comb begin
      producer_d = producer_q;
      consumer_d = consumer_q;
      cnt_d      = cnt_q;
      if (bus.ptr_wr_en) begin
         producer_d = bus.ptr_wr_data;
      end else begin
         producer_d = producer_q;
      end
      if (state_q == ST_DONE) begin
         consumer_d = ~consumer_q;
      end else begin
         consumer_d = consumer_q;
      end
      // Counter reads 0 during START, counts each BUSY cycle, holds otherwise
      if (state_d == ST_START) begin
         cnt_d = {CNT_W{1'b0}};
      end else if ((state_q == ST_BUSY) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Control and status registers
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         op_en_q    <= 2'b00;
         producer_q <= 1'b0;
         consumer_q <= 1'b0;
         wr_err_q   <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
      end else begin
         op_en_q    <= op_en_d;
         producer_q <= producer_d;
         consumer_q <= consumer_d;
         wr_err_q   <= wr_err_d;
         cnt_q      <= cnt_d;
      end
   end

   // Outputs are registers or decodes of the registered state
   assign bus.op_en       = op_en_q;
   assign bus.producer    = producer_q;
   assign bus.consumer    = consumer_q;
   assign bus.dp_sel      = consumer_q;
   assign bus.dp_start    = (state_q == ST_START);
   assign bus.done_intr   = {(state_q == ST_DONE) &&  consumer_q,
                             (state_q == ST_DONE) && !consumer_q};
   assign bus.wr_err      = wr_err_q;
   assign bus.ctrl_busy   = (state_q != ST_IDLE);
   assign bus.busy_cycles = cnt_q;

endmodule
